// File: rtl/dcache_controller_if.sv
// ============================================================================
// Module      : dcache_controller_if
// Description : CPU, main-memory and cache-SRAM signals of dcache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_controller_if;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic         cpu_MemRead_i;
   logic         cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;

   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic [255:0] mem_data_o;
   logic [31:0]  mem_addr_o;
   logic         mem_enable_o;
   logic         mem_write_o;

   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_enable_o;
   logic         sram_write_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;

   // Controller side
   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output cpu_data_o, cpu_stall_o,
      input  mem_data_i, mem_ack_i,
      output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
      output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      input  sram_tag_i, sram_data_i, sram_hit_i
   );

   // Environment side: pipeline, memory and SRAM
   modport master (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  cpu_data_o, cpu_stall_o,
      output mem_data_i, mem_ack_i,
      input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
      input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
      output sram_tag_i, sram_data_i, sram_hit_i
   );
endinterface

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================================
// Module      : dcache_controller
// Description : 2-way/16-set/32-byte-line data-cache controller with
//               write-back of dirty victims, refill and store merge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_controller (
   input  logic clk_i,
   input  logic rst_i,
   dcache_controller_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_MISS       = 3'd1,
      S_WRITEBACK  = 3'd2,
      S_READMISS   = 3'd3,
      S_READMISSOK = 3'd4
   } state_t;

   state_t       r_state;
   state_t       w_next;
   logic [24:0]  r_victim_tag;
   logic [255:0] r_victim_data;
   logic [255:0] r_refill_data;

   logic         w_req;
   logic [22:0]  w_tag;
   logic [3:0]   w_index;
   logic [2:0]   w_word;
   logic [255:0] w_merged;
   logic         w_unused;

   assign w_req    = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign w_tag    = bus.cpu_addr_i[31:9];
   assign w_index  = bus.cpu_addr_i[8:5];
   assign w_word   = bus.cpu_addr_i[4:2];
   assign w_unused = &{1'b0, bus.cpu_addr_i[1:0]};

   assign bus.sram_addr_o   = w_index;
   assign bus.sram_enable_o = w_req | (r_state != S_IDLE);
   assign bus.cpu_data_o    = bus.sram_data_i[{w_word, 5'b0} +: 32];

   always_comb begin
      w_merged = bus.sram_data_i;
      w_merged[{w_word, 5'b0} +: 32] = bus.cpu_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_victim_tag  <= '0;
         r_victim_data <= '0;
         r_refill_data <= '0;
      end else begin
         r_state <= w_next;
         // On a miss the SRAM presents the LRU way, which becomes the victim
         if (r_state == S_IDLE && w_req && !bus.sram_hit_i) begin
            r_victim_tag  <= bus.sram_tag_i;
            r_victim_data <= bus.sram_data_i;
         end
         if (r_state == S_READMISS && bus.mem_ack_i) begin
            r_refill_data <= bus.mem_data_i;
         end
      end
   end

   always_comb begin
      w_next           = r_state;
      bus.cpu_stall_o  = 1'b1;
      bus.sram_write_o = 1'b0;
      bus.sram_tag_o   = {1'b1, bus.cpu_MemWrite_i, w_tag};
      bus.sram_data_o  = w_merged;
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
      case (r_state)
         S_IDLE: begin
            bus.cpu_stall_o = w_req & ~bus.sram_hit_i;
            if (w_req) begin
               if (bus.sram_hit_i) begin
                  bus.sram_write_o = bus.cpu_MemWrite_i;
               end else begin
                  w_next = S_MISS;
               end
            end
         end
         S_MISS: begin
            w_next = (r_victim_tag[24] && r_victim_tag[23]) ? S_WRITEBACK : S_READMISS;
         end
         S_WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = {r_victim_tag[22:0], w_index, 5'b0};
            bus.mem_data_o   = r_victim_data;
            if (bus.mem_ack_i) w_next = S_READMISS;
         end
         S_READMISS: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = {w_tag, w_index, 5'b0};
            if (bus.mem_ack_i) w_next = S_READMISSOK;
         end
         S_READMISSOK: begin
            bus.sram_write_o = 1'b1;
            bus.sram_tag_o   = {1'b1, 1'b0, w_tag};
            bus.sram_data_o  = r_refill_data;
            w_next           = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
// Module      : tb_dcache_controller
// Description : Bench for dcache_controller with SRAM/memory models and a
//               word-level reference of memory contents and cache residency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_controller;

   logic clk;
   logic rst;
   dcache_controller_if bus ();

   dcache_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   function automatic logic [31:0] word_init(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [255:0] line_init(input logic [26:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = word_init({la, w[2:0], 2'b00});
      return l;
   endfunction

   // ---------------- main memory model ----------------
   int           lat = 10;
   int           mcnt;
   logic [255:0] mem_lines [logic [26:0]];
   int           wb_count = 0;
   logic [31:0]  wb_addr;
   logic [255:0] wb_data;

   function automatic logic [255:0] mem_get(input logic [26:0] la);
      if (mem_lines.exists(la)) return mem_lines[la];
      return line_init(la);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mcnt = 0;
         bus.mem_ack_i <= 1'b0;
      end else if (bus.mem_ack_i) begin
         if (bus.mem_write_o) begin
            mem_lines[bus.mem_addr_o[31:5]] = bus.mem_data_o;
            wb_count = wb_count + 1;
            wb_addr  = bus.mem_addr_o;
            wb_data  = bus.mem_data_o;
         end
         bus.mem_ack_i <= 1'b0;
         mcnt = 0;
      end else if (bus.mem_enable_o) begin
         mcnt = mcnt + 1;
         if (mcnt >= lat - 1) begin
            bus.mem_ack_i  <= 1'b1;
            bus.mem_data_i <= mem_get(bus.mem_addr_o[31:5]);
         end
      end
   end

   // ---------------- 2-way SRAM model with LRU ----------------
   logic [24:0]  s_tag  [16][2];
   logic [255:0] s_data [16][2];
   logic         s_lru  [16];
   logic         w_h0, w_h1, w_way;
   int           swr_count = 0;
   logic [24:0]  last_tag;
   logic [255:0] last_data;

   always_comb begin
      w_h0 = s_tag[bus.sram_addr_o][0][24] && (s_tag[bus.sram_addr_o][0][22:0] == bus.sram_tag_o[22:0]);
      w_h1 = s_tag[bus.sram_addr_o][1][24] && (s_tag[bus.sram_addr_o][1][22:0] == bus.sram_tag_o[22:0]);
      w_way = w_h0 ? 1'b0 : (w_h1 ? 1'b1 : s_lru[bus.sram_addr_o]);
      bus.sram_hit_i  = w_h0 | w_h1;
      bus.sram_tag_i  = s_tag[bus.sram_addr_o][w_way];
      bus.sram_data_i = s_data[bus.sram_addr_o][w_way];
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            s_tag[i][0]  <= '0;
            s_tag[i][1]  <= '0;
            s_data[i][0] <= '0;
            s_data[i][1] <= '0;
            s_lru[i]     <= 1'b0;
         end
      end else if (bus.sram_enable_o) begin
         if (bus.sram_write_o) begin
            s_tag[bus.sram_addr_o][w_way]  <= bus.sram_tag_o;
            s_data[bus.sram_addr_o][w_way] <= bus.sram_data_o;
            s_lru[bus.sram_addr_o]         <= ~w_way;
            swr_count                      <= swr_count + 1;
            last_tag                       <= bus.sram_tag_o;
            last_data                      <= bus.sram_data_o;
         end else if (bus.sram_hit_i) begin
            s_lru[bus.sram_addr_o] <= ~w_way;
         end
      end
   end

   // ---------------- reference: coherent word view + set residency ----------------
   logic [31:0] ref_words [logic [31:0]];
   logic [22:0] rtag [16][2];   // slot 0 = least recently used
   bit          rdty [16][2];
   int          rn   [16];

   task automatic ref_access(input logic [31:0] a, input logic [31:0] d, input bit wr,
                             output int exp_stall, output logic [31:0] exp_rdata);
      int          idx;
      int          p;
      logic [22:0] tg;
      logic [22:0] tt;
      bit          td;
      idx = int'(a[8:5]);
      tg  = a[31:9];
      p   = -1;
      for (int i = 0; i < rn[idx]; i++) if (rtag[idx][i] == tg) p = i;
      if (p >= 0) begin
         exp_stall = 0;
         if (p == 0 && rn[idx] == 2) begin
            tt = rtag[idx][0]; td = rdty[idx][0];
            rtag[idx][0] = rtag[idx][1]; rdty[idx][0] = rdty[idx][1];
            rtag[idx][1] = tt;           rdty[idx][1] = td;
         end
      end else begin
         exp_stall = 3 + lat;
         if (rn[idx] == 2) begin
            if (rdty[idx][0]) exp_stall = exp_stall + lat;
            rtag[idx][0] = rtag[idx][1];
            rdty[idx][0] = rdty[idx][1];
            rn[idx]      = 1;
         end
         rtag[idx][rn[idx]] = tg;
         rdty[idx][rn[idx]] = 1'b0;
         rn[idx]            = rn[idx] + 1;
      end
      exp_rdata = ref_words.exists(a) ? ref_words[a] : word_init(a);
      if (wr) begin
         ref_words[a]           = d;
         rdty[idx][rn[idx] - 1] = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU request held until the stall drops, then through its hit cycle
   task automatic run(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                      output int stalls, output logic [31:0] rdata);
      int          es;
      logic [31:0] ed;
      @(negedge clk);
      bus.cpu_addr_i     = a;
      bus.cpu_data_i     = d;
      bus.cpu_MemRead_i  = rd;
      bus.cpu_MemWrite_i = wr;
      stalls = 0;
      #1;
      while (bus.cpu_stall_o === 1'b1 && stalls < 2000) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      check("stall_release", {255'b0, bus.cpu_stall_o}, 256'd0);
      rdata = bus.cpu_data_o;
      @(posedge clk);
      #1;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      ref_access(a, d, wr, es, ed);
      check("stall_cycles", 256'(stalls), 256'(es));
      if (!wr) check("load_data", {224'b0, rdata}, {224'b0, ed});
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           st;
      logic [31:0]  rdv;
      int           wb0;
      int           sw0;
      logic [255:0] exp_line;
      logic [31:0]  a;
      bit           wr;
      bit           rd;

      for (int i = 0; i < 16; i++) rn[i] = 0;
      rst = 1'b1;
      bus.cpu_addr_i     = '0;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_stall",   {255'b0, bus.cpu_stall_o},  256'd0);
      check("rst_mem_en",  {255'b0, bus.mem_enable_o}, 256'd0);
      check("rst_mem_wr",  {255'b0, bus.mem_write_o},  256'd0);
      check("rst_mem_addr", {224'b0, bus.mem_addr_o},  256'd0);
      check("rst_mem_data", bus.mem_data_o,            256'd0);

      // reset in the middle of a refill
      lat = 50;
      @(negedge clk);
      bus.cpu_addr_i    = 32'h0000_0144;
      bus.cpu_MemRead_i = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("rm_mem_en",   {255'b0, bus.mem_enable_o}, 256'd1);
      check("rm_mem_wr",   {255'b0, bus.mem_write_o},  256'd0);
      check("rm_mem_addr", {224'b0, bus.mem_addr_o},   256'h140);
      @(negedge clk);
      rst = 1'b1;
      bus.cpu_MemRead_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_mem_en", {255'b0, bus.mem_enable_o},  256'd0);
      check("post_rst_stall",  {255'b0, bus.cpu_stall_o},   256'd0);
      check("post_rst_sram_en", {255'b0, bus.sram_enable_o}, 256'd0);

      // clean load miss
      lat = 10;
      run(32'h0000_0044, 32'h0, 1'b1, 1'b0, st, rdv);
      check("clean_miss_13", 256'(st), 256'd13);
      check("refill_tag", {231'b0, last_tag}, {231'b0, 1'b1, 1'b0, 23'h0});

      // store hit into the refilled line
      run(32'h0000_0048, 32'hDEAD_BEEF, 1'b0, 1'b1, st, rdv);
      check("store_hit_0", 256'(st), 256'd0);
      check("store_hit_tag", {231'b0, last_tag}, {231'b0, 1'b1, 1'b1, 23'h0});
      check("store_hit_word", {224'b0, last_data[95:64]}, {224'b0, 32'hDEAD_BEEF});

      // fill the other way, then evict the dirty line
      run(32'h0000_0244, 32'h0, 1'b1, 1'b0, st, rdv);
      wb0 = wb_count;
      run(32'h0000_0444, 32'h0, 1'b1, 1'b0, st, rdv);
      check("dirty_miss_23", 256'(st), 256'd23);
      check("wb_count", 256'(wb_count), 256'(wb0 + 1));
      check("wb_addr", {224'b0, wb_addr}, 256'h40);
      exp_line = line_init(27'd2);
      exp_line[95:64] = 32'hDEAD_BEEF;
      check("wb_data", wb_data, exp_line);
      run(32'h0000_0048, 32'h0, 1'b1, 1'b0, st, rdv);

      // store miss to a clean set
      sw0 = swr_count;
      run(32'h0000_06AC, 32'h1234_5678, 1'b0, 1'b1, st, rdv);
      check("store_miss_writes", 256'(swr_count), 256'(sw0 + 2));
      check("store_miss_tag", {231'b0, last_tag}, {231'b0, 1'b1, 1'b1, 23'h3});
      exp_line = line_init(27'h35);
      exp_line[127:96] = 32'h1234_5678;
      check("store_miss_line", last_data, exp_line);

      // read and write together on a hit act as a store
      sw0 = swr_count;
      run(32'h0000_06A0, 32'hCAFE_F00D, 1'b1, 1'b1, st, rdv);
      check("rdwr_written", 256'(swr_count), 256'(sw0 + 1));
      check("rdwr_word", {224'b0, last_data[31:0]}, {224'b0, 32'hCAFE_F00D});
      check("rdwr_tag", {231'b0, last_tag}, {231'b0, 1'b1, 1'b1, 23'h3});

      // randomized traffic over a few conflicting sets
      for (int n = 0; n < 80; n++) begin
         lat = $urandom_range(2, 6);
         a = {20'h0, 3'($urandom_range(0, 3)), 4'($urandom_range(0, 3) * 3 + 2),
              3'($urandom_range(0, 7)), 2'b00};
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         run(a, $urandom, rd, wr, st, rdv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
